// File: rtl/odma_lite_pkg.sv
// odma_lite_pkg
//   Shared constants for the ODMA action AXI4-Lite register bank: register
//   word indices, AXI response codes and CONTROL register bit positions.
//   No ports; imported by odma_action_lite_regs.
package odma_lite_pkg;

  // Word indices of the register map; scratch registers start at REG_SCRATCH_BASE.
  localparam int unsigned REG_ID           = 0;
  localparam int unsigned REG_CTRL         = 1;
  localparam int unsigned REG_STATUS       = 2;
  localparam int unsigned REG_CYCLE        = 3;
  localparam int unsigned REG_SCRATCH_BASE = 4;

  // Bit positions inside the CONTROL register.
  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_CLEAR_BIT = 1;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } axil_resp_e;

endpackage

// File: rtl/odma_action_lite_regs.sv
// odma_action_lite_regs
//   AXI4-Lite slave register bank for ODMA unit-sim actions. Provides an ID
//   register, a start/clear CONTROL register, a live STATUS window, a
//   free-running CYCLE counter and NUM_SCRATCH byte-strobed scratch registers.
// Ports
//   clk, resetn            clock, asynchronous active-low reset
//   s_lite_aw*/w*/b*       AXI-Lite write address / data / response channels
//   s_lite_ar*/r*          AXI-Lite read address / data channels
//   action_status          live status word from the action, sampled on read
//   action_start           one-cycle start pulse after a CONTROL start write
//   scratch_q              scratch contents, register k at [k*W +: W]
module odma_action_lite_regs
  import odma_lite_pkg::*;
#(
  parameter int          AXIL_ADDR_WIDTH = 32,
  parameter int          AXIL_DATA_WIDTH = 32,
  parameter int          NUM_SCRATCH     = 8,
  parameter logic [31:0] ACTION_ID       = 32'h0DAC_0001
) (
  input  logic                                   clk,
  input  logic                                   resetn,
  input  logic                                   s_lite_awvalid,
  output logic                                   s_lite_awready,
  input  logic [AXIL_ADDR_WIDTH-1:0]             s_lite_awaddr,
  input  logic                                   s_lite_wvalid,
  output logic                                   s_lite_wready,
  input  logic [AXIL_DATA_WIDTH-1:0]             s_lite_wdata,
  input  logic [AXIL_DATA_WIDTH/8-1:0]           s_lite_wstrb,
  output logic                                   s_lite_bvalid,
  input  logic                                   s_lite_bready,
  output logic [1:0]                             s_lite_bresp,
  input  logic                                   s_lite_arvalid,
  output logic                                   s_lite_arready,
  input  logic [AXIL_ADDR_WIDTH-1:0]             s_lite_araddr,
  output logic                                   s_lite_rvalid,
  input  logic                                   s_lite_rready,
  output logic [AXIL_DATA_WIDTH-1:0]             s_lite_rdata,
  output logic [1:0]                             s_lite_rresp,
  input  logic [AXIL_DATA_WIDTH-1:0]             action_status,
  output logic                                   action_start,
  output logic [NUM_SCRATCH*AXIL_DATA_WIDTH-1:0] scratch_q
);

  localparam int STRB_W   = AXIL_DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = AXIL_ADDR_WIDTH - ADDR_LSB;
  localparam int NUM_REGS = REG_SCRATCH_BASE + NUM_SCRATCH;

  if (!(AXIL_DATA_WIDTH == 32 || AXIL_DATA_WIDTH == 64)) begin : g_bad_data_width
    $error("odma_action_lite_regs: AXIL_DATA_WIDTH must be 32 or 64");
  end
  if (NUM_SCRATCH < 1 || NUM_SCRATCH > 64) begin : g_bad_num_scratch
    $error("odma_action_lite_regs: NUM_SCRATCH must be 1..64");
  end

  logic                       ready_en;
  logic                       aw_held;
  logic [IDX_W-1:0]           aw_idx_q;
  logic                       w_held;
  logic [AXIL_DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]          w_strb_q;
  logic [AXIL_DATA_WIDTH-1:0] cycle_q;

  logic                       aw_fire, w_fire, ar_fire, do_write;
  logic [IDX_W-1:0]           wr_idx, rd_idx;
  logic [AXIL_DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]          wr_strb;
  logic                       wr_in_range, rd_in_range;
  logic                       ctrl_hit, do_start, do_clear;
  logic [AXIL_DATA_WIDTH-1:0] rd_data_next;
  logic                       unused_addr_lsbs;

  // Byte-offset bits below the word index carry no meaning here.
  assign unused_addr_lsbs = ^{s_lite_awaddr[ADDR_LSB-1:0], s_lite_araddr[ADDR_LSB-1:0]};

  // Readies stay low until the first clock edge after reset releases.
  assign s_lite_awready = ready_en & ~aw_held & ~s_lite_bvalid;
  assign s_lite_wready  = ready_en & ~w_held & ~s_lite_bvalid;
  assign s_lite_arready = ready_en & ~s_lite_rvalid;

  assign aw_fire = s_lite_awvalid & s_lite_awready;
  assign w_fire  = s_lite_wvalid & s_lite_wready;
  assign ar_fire = s_lite_arvalid & s_lite_arready;

  // A channel counts as present either from its holding register or from a
  // handshake in this very cycle, so simultaneous AW+W updates immediately.
  assign wr_idx   = aw_held ? aw_idx_q : s_lite_awaddr[AXIL_ADDR_WIDTH-1:ADDR_LSB];
  assign wr_data  = w_held ? w_data_q : s_lite_wdata;
  assign wr_strb  = w_held ? w_strb_q : s_lite_wstrb;
  assign do_write = (aw_held | aw_fire) & (w_held | w_fire);

  assign wr_in_range = wr_idx < IDX_W'(NUM_REGS);
  assign ctrl_hit    = do_write & (wr_idx == IDX_W'(REG_CTRL)) & wr_strb[0];
  assign do_start    = ctrl_hit & wr_data[CTRL_START_BIT];
  assign do_clear    = ctrl_hit & wr_data[CTRL_CLEAR_BIT];

  assign rd_idx      = s_lite_araddr[AXIL_ADDR_WIDTH-1:ADDR_LSB];
  assign rd_in_range = rd_idx < IDX_W'(NUM_REGS);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ready_en <= 1'b0;
    else         ready_en <= 1'b1;
  end

  // Write holding registers: each channel latches on its own handshake and
  // both are released together on the update cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_held  <= 1'b0;
      aw_idx_q <= '0;
      w_held   <= 1'b0;
      w_data_q <= '0;
      w_strb_q <= '0;
    end else if (do_write) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_fire) begin
        aw_held  <= 1'b1;
        aw_idx_q <= s_lite_awaddr[AXIL_ADDR_WIDTH-1:ADDR_LSB];
      end
      if (w_fire) begin
        w_held   <= 1'b1;
        w_data_q <= s_lite_wdata;
        w_strb_q <= s_lite_wstrb;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s_lite_bvalid <= 1'b0;
      s_lite_bresp  <= RESP_OKAY;
    end else if (do_write) begin
      s_lite_bvalid <= 1'b1;
      s_lite_bresp  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (s_lite_bvalid && s_lite_bready) begin
      s_lite_bvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) action_start <= 1'b0;
    else         action_start <= do_start;
  end

  // Clear takes priority over the free-running increment.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)       cycle_q <= '0;
    else if (do_clear) cycle_q <= '0;
    else               cycle_q <= cycle_q + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scratch_q <= '0;
    end else if (do_write) begin
      for (int k = 0; k < NUM_SCRATCH; k++) begin
        if (wr_idx == IDX_W'(REG_SCRATCH_BASE + k)) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (wr_strb[b])
              scratch_q[k*AXIL_DATA_WIDTH + b*8 +: 8] <= wr_data[b*8 +: 8];
          end
        end
      end
    end
  end

  // Read mux sees pre-edge state, so a same-cycle write returns the old value.
  always_comb begin
    rd_data_next = '0;
    if (rd_idx == IDX_W'(REG_ID))     rd_data_next = AXIL_DATA_WIDTH'(ACTION_ID);
    if (rd_idx == IDX_W'(REG_STATUS)) rd_data_next = action_status;
    if (rd_idx == IDX_W'(REG_CYCLE))  rd_data_next = cycle_q;
    for (int k = 0; k < NUM_SCRATCH; k++) begin
      if (rd_idx == IDX_W'(REG_SCRATCH_BASE + k))
        rd_data_next = scratch_q[k*AXIL_DATA_WIDTH +: AXIL_DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s_lite_rvalid <= 1'b0;
      s_lite_rdata  <= '0;
      s_lite_rresp  <= RESP_OKAY;
    end else if (ar_fire) begin
      s_lite_rvalid <= 1'b1;
      s_lite_rdata  <= rd_data_next;
      s_lite_rresp  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (s_lite_rvalid && s_lite_rready) begin
      s_lite_rvalid <= 1'b0;
    end
  end

endmodule
